// File: rtl/aq_mmu_utlb_refill.sv
// uTLB miss handler: requests a translation from the jTLB and refills one victim uTLB entry.
// Optional build macro AQ_MMU_UTLB_MISS_CNT_EN enables the saturating miss counter.
module aq_mmu_utlb_refill #(
    parameter int ENTRY_NUM = 8,
    parameter int VPN_WIDTH = 28,
    parameter int FLG_WIDTH = 15,
    parameter int PGS_WIDTH = 3
) (
    input  logic                 mmu_top_clk,
    input  logic                 cpurst_b,
    input  logic                 utlb_req_vld,
    input  logic [VPN_WIDTH-1:0] utlb_req_vpn,
    input  logic [ENTRY_NUM-1:0] utlb_entry_hit,
    input  logic [ENTRY_NUM-1:0] utlb_entry_vld,
    input  logic                 utlb_flush,
    output logic                 utlb_jtlb_req,
    output logic [VPN_WIDTH-1:0] utlb_jtlb_vpn,
    input  logic                 jtlb_utlb_grant,
    input  logic                 jtlb_utlb_resp_vld,
    input  logic                 jtlb_utlb_resp_fault,
    input  logic [VPN_WIDTH-1:0] jtlb_utlb_ppn,
    input  logic [FLG_WIDTH-1:0] jtlb_utlb_flg,
    input  logic [PGS_WIDTH-1:0] jtlb_utlb_pgs,
    input  logic                 jtlb_utlb_mmu_on,
    output logic [ENTRY_NUM-1:0] utlb_entry_upd,
    output logic [VPN_WIDTH-1:0] utlb_upd_vpn,
    output logic [VPN_WIDTH-1:0] utlb_upd_ppn,
    output logic [FLG_WIDTH-1:0] utlb_upd_flg,
    output logic [PGS_WIDTH-1:0] utlb_upd_pgs,
    output logic                 utlb_upd_mmu_on,
    output logic                 utlb_miss_stall,
    output logic                 utlb_fault,
    output logic [15:0]          utlb_miss_cnt
);

    localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ENTRY_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_UPD  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [VPN_WIDTH-1:0]   vpn_q, vpn_d;
    logic                   discard_q, discard_d;
    logic                   fault_q, fault_d;
    logic [VPN_WIDTH-1:0]   ppn_q, ppn_d;
    logic [FLG_WIDTH-1:0]   flg_q, flg_d;
    logic [PGS_WIDTH-1:0]   pgs_q, pgs_d;
    logic                   mmu_on_q, mmu_on_d;
    logic [PTR_W-1:0]       rr_q, rr_d;
    logic                   miss_s;
    logic                   all_vld_s;
    logic [PTR_W-1:0]       victim_s;
    logic [ENTRY_NUM-1:0]   upd_s;

    // Lowest-index invalid entry; only meaningful when at least one entry is free.
    function automatic logic [PTR_W-1:0] first_free(input logic [ENTRY_NUM-1:0] vld);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!vld[i]) begin
                idx = PTR_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign miss_s    = utlb_req_vld && ~|utlb_entry_hit;
    assign all_vld_s = &utlb_entry_vld;
    assign victim_s  = all_vld_s ? rr_q : first_free(utlb_entry_vld);

    // Next-state, refill bookkeeping and update strobe decode.
    always_comb begin
        state_d   = state_q;
        vpn_d     = vpn_q;
        discard_d = discard_q;
        fault_d   = 1'b0;
        ppn_d     = ppn_q;
        flg_d     = flg_q;
        pgs_d     = pgs_q;
        mmu_on_d  = mmu_on_q;
        rr_d      = rr_q;
        upd_s     = '0;
        case (state_q)
            ST_IDLE: begin
                discard_d = 1'b0;
                if (miss_s && !utlb_flush) begin
                    vpn_d   = utlb_req_vpn;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (jtlb_utlb_grant) begin
                    // The jTLB already owns the request, so a flush can only mark it stale.
                    discard_d = utlb_flush;
                    state_d   = ST_WAIT;
                end else if (utlb_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (jtlb_utlb_resp_vld) begin
                    discard_d = 1'b0;
                    if (discard_q || utlb_flush) begin
                        state_d = ST_IDLE;
                    end else if (jtlb_utlb_resp_fault) begin
                        fault_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ppn_d    = jtlb_utlb_ppn;
                        flg_d    = jtlb_utlb_flg;
                        pgs_d    = jtlb_utlb_pgs;
                        mmu_on_d = jtlb_utlb_mmu_on;
                        state_d  = ST_UPD;
                    end
                end else if (utlb_flush) begin
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
            end
            ST_UPD: begin
                state_d = ST_IDLE;
                if (!utlb_flush) begin
                    upd_s[victim_s] = 1'b1;
                    if (all_vld_s) begin
                        rr_d = (rr_q == PTR_LAST) ? '0 : rr_q + PTR_W'(1);
                    end else begin
                        rr_d = rr_q;
                    end
                end else begin
                    upd_s = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge mmu_top_clk) begin
        if (!cpurst_b) begin
            state_q   <= ST_IDLE;
            vpn_q     <= '0;
            discard_q <= 1'b0;
            fault_q   <= 1'b0;
            ppn_q     <= '0;
            flg_q     <= '0;
            pgs_q     <= '0;
            mmu_on_q  <= 1'b0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            vpn_q     <= vpn_d;
            discard_q <= discard_d;
            fault_q   <= fault_d;
            ppn_q     <= ppn_d;
            flg_q     <= flg_d;
            pgs_q     <= pgs_d;
            mmu_on_q  <= mmu_on_d;
            rr_q      <= rr_d;
        end
    end

`ifdef AQ_MMU_UTLB_MISS_CNT_EN
    logic [15:0] miss_cnt_q;

    // Saturating count of refills started.
    always_ff @(posedge mmu_top_clk) begin
        if (!cpurst_b) begin
            miss_cnt_q <= 16'h0000;
        end else if ((state_q == ST_IDLE) && (state_d == ST_REQ) && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_q <= miss_cnt_q + 16'h0001;
        end else begin
            miss_cnt_q <= miss_cnt_q;
        end
    end

    assign utlb_miss_cnt = miss_cnt_q;
`else
    assign utlb_miss_cnt = 16'h0000;
`endif

    assign utlb_jtlb_req   = (state_q == ST_REQ);
    assign utlb_jtlb_vpn   = vpn_q;
    assign utlb_entry_upd  = upd_s;
    assign utlb_upd_vpn    = vpn_q;
    assign utlb_upd_ppn    = ppn_q;
    assign utlb_upd_flg    = flg_q;
    assign utlb_upd_pgs    = pgs_q;
    assign utlb_upd_mmu_on = mmu_on_q;
    assign utlb_miss_stall = (state_q != ST_IDLE) || miss_s;
    assign utlb_fault      = fault_q;

endmodule
